md5_core_dispatcher: RTL and testbench

//  Round-robin scheduler that shares one candidate-message stream between N_CORES

---
 rtl/md5_core_dispatcher.sv | 139 +++++++++++++
 tb/tb_md5_core_dispatcher.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/md5_core_dispatcher.sv
// rtl/md5_core_dispatcher.sv - round-robin candidate dispatcher for N MD5 cores
// Hands candidates to free cores, compares digests to the target, halts on first match.
module md5_core_dispatcher #(
   parameter int N_CORES   = 2,
   parameter int IDX_W     = 3,
   parameter int MSG_W_VAL = 64
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [127:0]           i_cand_data,
   input  logic                   i_cand_valid,
   output logic                   o_cand_ready,
   input  logic [127:0]           i_target,
   input  logic                   i_clear,
   input  logic [N_CORES-1:0]     i_core_ready,
   input  logic [N_CORES-1:0]     i_core_out_valid,
   input  logic [128*N_CORES-1:0] i_core_digest,
   output logic [128*N_CORES-1:0] o_core_msg,
   output logic [8*N_CORES-1:0]   o_core_msg_width,
   output logic [N_CORES-1:0]     o_core_msg_valid,
   output logic                   o_found,
   output logic [IDX_W-1:0]       o_found_core,
   output logic [127:0]           o_found_msg,
   output logic [31:0]            o_hash_count
);

   typedef enum logic {ST_RUN, ST_HALT} state_t;

   state_t                 r_state, w_state_next;
   logic [N_CORES-1:0]     r_busy, r_msg_valid;
   logic [N_CORES-1:0]     w_elig, w_done, w_pick_oh, w_match_oh;
   logic [IDX_W-1:0]       r_rr_ptr, w_next_ptr, w_match_idx;
   logic                   w_pick_ok, w_dispatch, w_any_match;
   logic [31:0]            w_done_cnt;
   logic [128*N_CORES-1:0] r_core_msg;
   logic                   r_found;
   logic [IDX_W-1:0]       r_found_core;
   logic [127:0]           r_found_msg;
   logic [31:0]            r_hash_count;

   assign w_elig       = i_core_ready & ~r_busy;
   assign w_done       = i_core_out_valid & r_busy;
   assign o_cand_ready = (r_state == ST_RUN) && (|w_elig);
   assign w_dispatch   = i_cand_valid && o_cand_ready;

   // Round-robin: lowest eligible core at/above rr_ptr, else wrap to lowest eligible.
   always_comb begin
      int v_hi, v_lo, v_pick;
      logic v_hi_ok;
      v_hi      = 0;
      v_lo      = 0;
      v_hi_ok   = 1'b0;
      w_pick_ok = 1'b0;
      for (int k = N_CORES - 1; k >= 0; k--) begin
         if (w_elig[k]) begin
            v_lo      = k;
            w_pick_ok = 1'b1;
            if (k >= int'(r_rr_ptr)) begin
               v_hi    = k;
               v_hi_ok = 1'b1;
            end
         end
      end
      v_pick = v_hi_ok ? v_hi : v_lo;
      for (int k = 0; k < N_CORES; k++) begin
         w_pick_oh[k] = w_pick_ok && (k == v_pick);
      end
      w_next_ptr = (v_pick + 1 >= N_CORES) ? '0 : IDX_W'(v_pick + 1);
   end

   always_comb begin
      w_match_oh  = '0;
      w_match_idx = '0;
      w_done_cnt  = '0;
      for (int k = N_CORES - 1; k >= 0; k--) begin
         w_done_cnt = w_done_cnt + {31'b0, w_done[k]};
         if (w_done[k] && (i_core_digest[128*k +: 128] == i_target)) begin
            w_match_oh     = '0;
            w_match_oh[k]  = 1'b1;
            w_match_idx    = IDX_W'(k);
         end
      end
      w_any_match = |w_match_oh;
   end

   // A match arriving together with clear keeps the dispatcher halted.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_RUN:  if (w_any_match) w_state_next = ST_HALT;
         ST_HALT: if (i_clear && !w_any_match) w_state_next = ST_RUN;
         default: w_state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= ST_RUN;
      else         r_state <= w_state_next;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_busy       <= '0;
         r_msg_valid  <= '0;
         r_rr_ptr     <= '0;
         r_core_msg   <= '0;
         r_found      <= 1'b0;
         r_found_core <= '0;
         r_found_msg  <= '0;
         r_hash_count <= '0;
      end else begin
         r_hash_count <= r_hash_count + w_done_cnt;
         r_found      <= (w_state_next == ST_HALT);
         for (int k = 0; k < N_CORES; k++) begin
            r_msg_valid[k] <= w_dispatch && w_pick_oh[k];
            if (w_dispatch && w_pick_oh[k]) begin
               r_busy[k]               <= 1'b1;
               r_core_msg[128*k +: 128] <= i_cand_data;
            end else if (w_done[k]) begin
               r_busy[k] <= 1'b0;
            end
            if ((r_state == ST_RUN) && w_match_oh[k]) begin
               r_found_msg <= r_core_msg[128*k +: 128];
            end
         end
         if (w_dispatch) r_rr_ptr <= w_next_ptr;
         if ((r_state == ST_RUN) && w_any_match) r_found_core <= w_match_idx;
      end
   end

   assign o_core_msg       = r_core_msg;
   assign o_core_msg_width = {N_CORES{8'(MSG_W_VAL)}};
   assign o_core_msg_valid = r_msg_valid;
   assign o_found          = r_found;
   assign o_found_core     = r_found_core;
   assign o_found_msg      = r_found_msg;
   assign o_hash_count     = r_hash_count;

endmodule

// File: tb/tb_md5_core_dispatcher.sv
// tb/tb_md5_core_dispatcher.sv - self-checking bench for md5_core_dispatcher
// Directed scenarios followed by randomized traffic, all checked against a reference model.
module tb_md5_core_dispatcher;

   localparam int N  = 2;
   localparam int IW = 3;

   logic             clk = 1'b0;
   logic             reset, cand_valid, clear;
   logic [127:0]     cand_data, target;
   logic [N-1:0]     core_ready, core_out_valid;
   logic [128*N-1:0] core_digest;
   logic             cand_ready, found;
   logic [128*N-1:0] core_msg;
   logic [8*N-1:0]   core_msg_width;
   logic [N-1:0]     core_msg_valid;
   logic [IW-1:0]    found_core;
   logic [127:0]     found_msg;
   logic [31:0]      hash_count;

   always #5 clk = ~clk;

   md5_core_dispatcher #(.N_CORES(N), .IDX_W(IW), .MSG_W_VAL(64)) dut (
      .i_clk(clk), .i_reset(reset), .i_cand_data(cand_data), .i_cand_valid(cand_valid),
      .o_cand_ready(cand_ready), .i_target(target), .i_clear(clear),
      .i_core_ready(core_ready), .i_core_out_valid(core_out_valid),
      .i_core_digest(core_digest), .o_core_msg(core_msg), .o_core_msg_width(core_msg_width),
      .o_core_msg_valid(core_msg_valid), .o_found(found), .o_found_core(found_core),
      .o_found_msg(found_msg), .o_hash_count(hash_count)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: per-core bookkeeping kept in plain arrays.
   bit           m_busy[N];
   bit           m_pulse[N];
   logic [127:0] m_msg[N];
   int           m_rr;
   bit           m_halt, m_found;
   int           m_fcore;
   logic [127:0] m_fmsg;
   int unsigned  m_count;

   function automatic int m_pick();
      for (int off = 0; off < N; off++) begin
         int c = (m_rr + off) % N;
         if (core_ready[c] && !m_busy[c]) return c;
      end
      return -1;
   endfunction

   function automatic bit m_cand_ready();
      return !m_halt && (m_pick() >= 0);
   endfunction

   task automatic model_edge();
      int  pick, winner;
      bit  disp;
      if (reset) begin
         for (int k = 0; k < N; k++) begin
            m_busy[k] = 0; m_pulse[k] = 0; m_msg[k] = '0;
         end
         m_rr = 0; m_halt = 0; m_found = 0; m_fcore = 0; m_fmsg = '0; m_count = 0;
         return;
      end
      pick   = m_pick();
      disp   = cand_valid && m_cand_ready();
      winner = -1;
      for (int k = 0; k < N; k++) begin
         m_pulse[k] = 0;
         if (core_out_valid[k] && m_busy[k]) begin
            m_busy[k] = 0;
            m_count++;
            if (winner < 0 && core_digest[128*k +: 128] == target) winner = k;
         end
      end
      if (!m_halt && winner >= 0) begin
         m_halt = 1; m_found = 1; m_fcore = winner; m_fmsg = m_msg[winner];
      end else if (m_halt && clear && winner < 0) begin
         m_halt = 0; m_found = 0;
      end
      if (disp) begin
         m_msg[pick] = cand_data; m_busy[pick] = 1; m_pulse[pick] = 1;
         m_rr = (pick + 1) % N;
      end
   endtask

   task automatic check_regs();
      for (int k = 0; k < N; k++) begin
         chk($sformatf("msg_valid%0d", k), core_msg_valid[k], m_pulse[k]);
         chk($sformatf("core_msg%0d", k), core_msg[128*k +: 128], m_msg[k]);
         chk($sformatf("msg_width%0d", k), core_msg_width[8*k +: 8], 8'd64);
      end
      chk("found", found, m_found);
      chk("found_core", found_core, 128'(m_fcore));
      chk("found_msg", found_msg, m_fmsg);
      chk("hash_count", hash_count, 128'(m_count));
   endtask

   // Inputs are already driven at the falling edge when this is called.
   task automatic step();
      #1 chk("cand_ready", cand_ready, m_cand_ready());
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_regs();
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic set_dig(input int k, input logic [127:0] v);
      core_digest[128*k +: 128] = v;
   endtask

   logic [127:0] msg_a, msg_b, msg_c, msg_d;

   initial begin
      target = rnd128();
      msg_a = rnd128(); msg_b = rnd128(); msg_c = rnd128(); msg_d = rnd128();
      reset = 1; cand_valid = 0; clear = 0; cand_data = '0;
      core_ready = '0; core_out_valid = '0; core_digest = '0;
      @(negedge clk);
      step(); step();
      chk("rst_cand_ready", cand_ready, 1'b0);
      chk("rst_hash_count", hash_count, 32'd0);
      reset = 0;

      // 1: back-to-back dispatch to core0 then core1
      core_ready = 2'b11; cand_valid = 1; cand_data = msg_a;
      step(); chk("t1_first", core_msg_valid, 2'b01);
      cand_data = msg_b;
      step(); chk("t1_second", core_msg_valid, 2'b10);
      step(); chk("t1_full", cand_ready, 1'b0);
      chk("t1_idle", core_msg_valid, 2'b00);

      // 2: core1 finishes first with a non-matching digest
      cand_valid = 0; core_out_valid = 2'b10; set_dig(1, ~target);
      step(); core_out_valid = 2'b00;
      chk("t2_count", hash_count, 32'd1);
      cand_valid = 1; cand_data = msg_c;
      step(); chk("t2_to_core1", core_msg_valid, 2'b10);

      // 3: core0 matches
      cand_valid = 0; core_out_valid = 2'b01; set_dig(0, target);
      step(); core_out_valid = 2'b00;
      chk("t3_found", found, 1'b1);
      chk("t3_core", found_core, 3'd0);
      chk("t3_msg", found_msg, msg_a);
      cand_valid = 1; cand_data = msg_d;
      step(); chk("t3_halt_ready", cand_ready, 1'b0);

      // 5: clear resumes dispatch from rr_ptr (core0)
      cand_valid = 0; clear = 1;
      step(); clear = 0;
      chk("t5_found", found, 1'b0);
      cand_valid = 1;
      step(); chk("t5_resume", core_msg_valid, 2'b01);
      cand_valid = 0;

      // 4: both cores match together, then a late core1 match
      core_out_valid = 2'b11; set_dig(0, target); set_dig(1, target);
      step();
      chk("t4_core", found_core, 3'd0);
      chk("t4_msg", found_msg, msg_d);
      chk("t4_count", hash_count, 32'd4);
      core_out_valid = 2'b10;
      step(); core_out_valid = 2'b00;
      chk("t4_late_msg", found_msg, msg_d);

      // 6: reset while both cores are busy, then a stale completion
      clear = 1; step(); clear = 0;
      cand_valid = 1; cand_data = msg_a; step(); cand_data = msg_b; step();
      cand_valid = 0; reset = 1;
      step(); reset = 0;
      chk("t6_msg", core_msg, '0);
      core_out_valid = 2'b11;
      step(); core_out_valid = 2'b00;
      chk("t6_count", hash_count, 32'd0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         reset          = ($urandom_range(0, 99) == 0);
         clear          = ($urandom_range(0, 15) == 0);
         cand_valid     = ($urandom_range(0, 3) != 0);
         cand_data      = rnd128();
         core_ready     = N'($urandom) | N'($urandom);
         core_out_valid = N'($urandom) & N'($urandom);
         for (int k = 0; k < N; k++) begin
            set_dig(k, ($urandom_range(0, 7) == 0) ? target : rnd128());
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
